// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: feeds a bit-serial adder LSB-first from a parallel
// operand handshake and reassembles the registered serial sum into a
// WIDTH+1-bit parallel result. Every output comes directly from a register.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_cin,
    output logic             ser_reset,
    input  logic             ser_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             ser_a_q, ser_a_d;
    logic             ser_b_q, ser_b_d;
    logic             ser_cin_q, ser_cin_d;
    logic             ser_reset_q, ser_reset_d;

    // State and all output registers, cleared asynchronously to the idle state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_cin_q   <= 1'b0;
            ser_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ser_a_q     <= ser_a_d;
            ser_b_q     <= ser_b_d;
            ser_cin_q   <= ser_cin_d;
            ser_reset_q <= ser_reset_d;
        end
    end

    // Next-state and next-output logic; bits are presented one cycle ahead
    // of the state they belong to because every output is registered
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ser_a_d     = ser_a_q;
        ser_b_d     = ser_b_q;
        ser_cin_d   = ser_cin_q;
        ser_reset_d = ser_reset_q;

        unique case (state_q)
            IDLE: begin
                ser_a_d     = 1'b0;
                ser_b_d     = 1'b0;
                ser_reset_d = 1'b1;
                in_ready_d  = 1'b1;
                if (in_valid && in_ready_q) begin
                    // Bit 0 goes straight out; the shifters keep the rest and
                    // backfill zeros so bit WIDTH is presented as 0.
                    ser_a_d     = op_a[0];
                    ser_b_d     = op_b[0];
                    a_sh_d      = {1'b0, op_a[WIDTH-1:1]};
                    b_sh_d      = {1'b0, op_b[WIDTH-1:1]};
                    ser_cin_d   = op_cin;
                    ser_reset_d = 1'b0;
                    in_ready_d  = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                // The adder's sum for bit k appears one cycle after bit k,
                // so capture starts in the second SHIFT cycle.
                if (cnt_q != '0) begin
                    sum_d = {ser_s, sum_q[WIDTH:1]};
                end
                if (cnt_q == LAST_BIT) begin
                    ser_a_d = 1'b0;
                    ser_b_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    ser_a_d = a_sh_q[0];
                    ser_b_d = b_sh_q[0];
                    a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Final capture: the carry-out bit
                sum_d       = {ser_s, sum_q[WIDTH:1]};
                ser_a_d     = 1'b0;
                ser_b_d     = 1'b0;
                ser_reset_d = 1'b1;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                ser_reset_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ser_a     = ser_a_q;
    assign ser_b     = ser_b_q;
    assign ser_cin   = ser_cin_q;
    assign ser_reset = ser_reset_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: includes a bit-serial adder model so the
// controller sees a real registered sum stream, and checks results against
// plain integer addition.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_cin;
    logic           ser_a;
    logic           ser_b;
    logic           ser_cin;
    logic           ser_reset;
    logic           ser_s;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     sum;

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_cin   (ser_cin),
        .ser_reset (ser_reset),
        .ser_s     (ser_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial adder: registered sum and carry, takes ser_cin on its
    // first clock after ser_reset drops.
    logic add_first, add_c, add_s, add_cin_eff;
    assign add_cin_eff = add_first ? ser_cin : add_c;
    assign ser_s       = add_s;

    always @(posedge clk) begin
        if (ser_reset) begin
            add_first <= 1'b1;
            add_c     <= 1'b0;
            add_s     <= 1'b0;
        end else begin
            add_first <= 1'b0;
            add_s     <= ser_a ^ ser_b ^ add_cin_eff;
            add_c     <= (ser_a & ser_b) | (ser_a & add_cin_eff) | (ser_b & add_cin_eff);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, stream, optional backpressure, handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int stall, input logic [W:0] exp, input string tag);
        int          waitc;
        int          lat;
        int          rlow;
        int          busy_bad;
        int          hold_bad;
        logic [W:0]  held;
        waitc = 0;
        out_ready = 1'b0;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        tick();
        // Junk on the input side while busy must be ignored
        op_a   = W'($urandom);
        op_b   = W'($urandom);
        op_cin = 1'($urandom);
        lat = 0; rlow = 0; busy_bad = 0;
        while (!out_valid && lat < 40) begin
            if (!ser_reset) rlow++;
            if (in_ready || ser_cin !== cin) busy_bad++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, W + 2);
        check({tag, "_ser_reset_low"}, rlow, W + 2);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_sum"}, sum, exp);
        held = sum;
        hold_bad = 0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!out_valid || sum !== held || in_ready || !ser_reset) hold_bad++;
        end
        check({tag, "_hold"}, hold_bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           stall;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];
        logic         bb_c[3];
        logic [W:0]   bb_e[3];
        int           acc_edge[3];
        int           nacc;
        int           nres;
        int           ready_cnt;
        logic         acc_now;
        int           stray;

        vecs[0] = '{a: 8'd200, b: 8'd100, cin: 1'b0, stall: 0, exp: 9'd300};
        vecs[1] = '{a: 8'hFF,  b: 8'hFF,  cin: 1'b1, stall: 0, exp: 9'h1FF};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   cin: 1'b0, stall: 0, exp: 9'd0};
        vecs[3] = '{a: 8'd55,  b: 8'd77,  cin: 1'b1, stall: 5, exp: 9'd133};
        vecs[4] = '{a: 8'd128, b: 8'd128, cin: 1'b0, stall: 2, exp: 9'd256};
        vecs[5] = '{a: 8'd1,   b: 8'hFF,  cin: 1'b0, stall: 1, exp: 9'h100};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_ser_ab", {ser_a, ser_b, ser_cin}, 0);
        check("rst_ser_reset", ser_reset, 1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Back-to-back with in_valid held and out_ready high throughout
        bb_a = '{8'd10, 8'd255, 8'd100};
        bb_b = '{8'd20, 8'd1,   8'd100};
        bb_c = '{1'b0,  1'b0,   1'b1};
        bb_e = '{9'd30, 9'd256, 9'd201};
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a = bb_a[0]; op_b = bb_b[0]; op_cin = bb_c[0];
        nacc = 0; nres = 0; ready_cnt = 0;
        for (int cyc = 0; cyc < 100 && nres < 3; cyc++) begin
            acc_now = in_ready && in_valid;
            if (in_ready) ready_cnt++;
            tick();
            if (acc_now) begin
                acc_edge[nacc] = cyc;
                nacc++;
                if (nacc < 3) begin
                    op_a = bb_a[nacc]; op_b = bb_b[nacc]; op_cin = bb_c[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check($sformatf("b2b_sum%0d", nres), sum, bb_e[nres]);
                check($sformatf("b2b_order%0d", nres), nacc, nres + 1);
                nres++;
            end
        end
        check("b2b_results", nres, 3);
        check("b2b_ready_samples", ready_cnt, 3);
        check("b2b_gap01", acc_edge[1] - acc_edge[0], W + 4);
        check("b2b_gap12", acc_edge[2] - acc_edge[1], W + 4);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;

        // Reset during the 4th SHIFT cycle of 55+77
        in_valid = 1'b1; op_a = 8'd55; op_b = 8'd77; op_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ser_reset", ser_reset, 1);
        check("midrst_sum", sum, 0);
        tick();
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid || !in_ready) stray++;
        end
        check("midrst_no_result", stray, 0);
        do_op(8'd55, 8'd77, 1'b1, 0, 9'd133, "post_rst");

        // Randomized operations against integer addition
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic [W:0]   re;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            re = (W+1)'(int'(ra) + int'(rb) + int'(rc));
            do_op(ra, rb, rc, int'($urandom_range(0, 3)), re, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Upstream/downstream controller for the bit-serial adder.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then streams them LSB-first on ser_a/ser_b.
- Manages the adder's reset, captures the adder's registered serial sum, and returns a WIDTH+1-bit parallel result over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_cin  input  1  carry-in.
- ser_a  output  1  serial bit of A to adder.
- ser_b  output  1  serial bit of B to adder.
- ser_cin  output  1  carry-in to adder.
- ser_reset  output  1  adder reset, active-high, registered.
- ser_s  input  1  adder registered sum bit.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH+1  op_a+op_b+op_cin; MSB is the final carry.

Behaviour:
- All outputs are registered; no combinational path from any input to any output.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, ser_a=0, ser_b=0, ser_cin=0, ser_reset=1. Bit counter=0.
- States:
  - IDLE: in_ready=1, ser_reset=1, ser_a=ser_b=0. On in_valid&in_ready at edge E0: latch op_a, op_b, op_cin into shift registers; in_ready→0, ser_reset→0, ser_cin→op_cin, ser_a/ser_b→bit0; next state SHIFT.
  - SHIFT: runs exactly WIDTH+1 cycles presenting bits 0..WIDTH. Bit WIDTH is presented as ser_a=ser_b=0 so the adder emits the final carry. ser_cin is held at the latched value for the whole operation, because the adder samples it on its first clock after reset. Next state DRAIN.
  - DRAIN: 1 cycle, ser_a=ser_b=0. Next state DONE.
  - DONE: out_valid=1, ser_reset=1, sum stable. On out_valid&out_ready: out_valid→0, next state IDLE (in_ready=1 the following cycle).
- Capture timing:
  - The adder registers s for bit k at edge E(k+1); the controller samples ser_s at edge E(k+2) into sum[k], k=0..WIDTH.
  - Capture is active from the 2nd SHIFT cycle through DRAIN (WIDTH+1 captures).
  - sum is filled by right-shifting ser_s into the MSB, so after the last capture sum[0]=s0.
- Latency: out_valid rises WIDTH+2 clocks after the accept edge (10 for WIDTH=8). Throughput: one operation per WIDTH+4 cycles minimum (1 IDLE cycle enforced).
- Arithmetic: sum = op_a + op_b + op_cin, exact in WIDTH+1 bits, no overflow possible.
- in_ready is 0 in SHIFT, DRAIN and DONE; in_valid is ignored there. Operand changes after accept have no effect.
- out_ready high before out_valid: no effect. out_ready held high: result is consumed in the single DONE cycle.
- Reset mid-operation: immediate return to reset values. Partial result is discarded, no out_valid. ser_reset=1 clears the adder.
- ser_reset is 1 in every state except SHIFT and DRAIN, so the adder's first-cycle flag is always re-armed between operations.

Test Plan:
- Reset, then op_a=8'd200, op_b=8'd100, op_cin=0, in_valid 1 cycle -> out_valid 10 clocks after accept edge, sum=9'd300; ser_reset low exactly 10 cycles.
- op_a=8'hFF, op_b=8'hFF, op_cin=1 -> sum=9'h1FF; op_a=0, op_b=0, op_cin=0 -> sum=0.
- Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> 3 results in order, each exactly one accept per out_valid; in_ready low during busy, 1 IDLE cycle between operations.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and sum held constant, in_ready=0; out_ready=1 -> completes, in_ready=1 next cycle.
- Assert reset at the 4th SHIFT cycle of 8'd55+8'd77 -> in_ready=1, out_valid=0, ser_reset=1 immediately; next op 8'd55+8'd77+1 -> sum=9'd133.
- Random: 200 random op_a/op_b/op_cin with random out_ready stalls, checked against the reference model A+B+cin.
